// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op/state encodings and default sizes for the EX-stage mul/div sequencer
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - EX-stage <-> mul/div sequencer signals; div_zero_o exists only with MULDIV_DIVZERO_EN
interface ex_muldiv_ctrl_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             mf_req_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
`ifdef MULDIV_DIVZERO_EN
  logic             div_zero_o;

  modport master (output start_i, op_i, rs_i, rt_i, mf_req_i,
                  input  stall_o, busy_o, done_o, hi_o, lo_o, div_zero_o);
  modport slave  (input  start_i, op_i, rs_i, rt_i, mf_req_i,
                  output stall_o, busy_o, done_o, hi_o, lo_o, div_zero_o);
`else
  modport master (output start_i, op_i, rs_i, rt_i, mf_req_i,
                  input  stall_o, busy_o, done_o, hi_o, lo_o);
  modport slave  (input  start_i, op_i, rs_i, rt_i, mf_req_i,
                  output stall_o, busy_o, done_o, hi_o, lo_o);
`endif
endinterface

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - shift-add multiply / restoring divide datapath, one bit per step
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;

  logic               sign_op, rs_neg, rt_neg, is_div_in, div_ge;
  logic [WIDTH-1:0]   rs_abs, rt_abs, div_diff;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [2*WIDTH-1:0] fixed;

  always_comb begin
    sign_op   = (op == OP_MULT) || (op == OP_DIV);
    is_div_in = (op == OP_DIV) || (op == OP_DIVU);
    rs_neg    = sign_op & rs[WIDTH-1];
    rt_neg    = sign_op & rt[WIDTH-1];
    rs_abs    = rs_neg ? -rs : rs;
    rt_abs    = rt_neg ? -rt : rt;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Partial remainder shifted left by one; its top bit matters for the compare only.
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = rem_sh >= {1'b0, opnd_q};
    div_diff  = rem_sh[WIDTH-1:0] - opnd_q;

    fixed = acc_q;
    if (!is_div_q) begin
      fixed = neg_q ? -acc_q : acc_q;
    end else begin
      fixed[2*WIDTH-1:WIDTH] = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fixed[WIDTH-1:0]       = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    end

    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    if (load) begin
      acc_d    = is_div_in ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
      opnd_d   = is_div_in ? rt_abs : rs_abs;
      is_div_d = is_div_in;
      neg_d    = rs_neg ^ rt_neg;
      rneg_d   = rs_neg;
    end else if (step) begin
      if (is_div_q) begin
        acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end else if (fix) begin
      acc_d = fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign res_hi = fixed[2*WIDTH-1:WIDTH];
  assign res_lo = fixed[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - MULT/MULTU/DIV/DIVU sequencer, HI/LO owner and pipeline stall source
// MULDIV_DIVZERO_EN: divide by zero finishes in one cycle and raises div_zero_o.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_muldiv_ctrl_if.slave    bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             load, step, fix;
  logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULDIV_DIVZERO_EN
  logic             dz_q, dz_d;
`endif

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .fix    (fix),
    .op     (bus.op_i),
    .rs     (bus.rs_i),
    .rt     (bus.rt_i),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    dz_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          load  = 1'b1;
          cnt_d = '0;
`ifdef MULDIV_DIVZERO_EN
          if (bus.op_i[1] && (bus.rt_i == '0)) begin
            state_d = S_DONE;
            hi_d    = bus.rs_i;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        // HI/LO take the sign-corrected result on the edge into DONE.
        fix     = 1'b1;
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign bus.stall_o = ((state_q == S_IDLE) & bus.start_i) | busy_q | (bus.mf_req_i & busy_q);
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign bus.div_zero_o = dz_q;
`endif

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_ctrl_if #(.WIDTH(32)) bus ();
  ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint s;
    logic [63:0] u;
    case (op)
      OP_MULT:  begin s = longint'($signed(rs)) * longint'($signed(rt)); u = s; end
      OP_MULTU: u = {32'h0, rs} * {32'h0, rt};
      OP_DIV: begin
        if (rt == 0) u = {rs, 32'hFFFFFFFF};
        else begin
          s = longint'($signed(rs)) % longint'($signed(rt)); u[63:32] = s[31:0];
          s = longint'($signed(rs)) / longint'($signed(rt)); u[31:0]  = s[31:0];
        end
      end
      default: u = (rt == 0) ? {rs, 32'hFFFFFFFF} : {rs % rt, rs / rt};
    endcase
    hi = u[63:32];
    lo = u[31:0];
  endfunction

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] eh, input logic [31:0] el, input int mf_at);
    logic [31:0] old_hi, old_lo;
    int c, lat, stall_cnt;
    logic held, seen, edz;
    edz = 1'b0;
    lat = 34;
`ifdef MULDIV_DIVZERO_EN
    if (op[1] && rt == 0) begin lat = 1; edz = 1'b1; end
`endif
    @(posedge clk); #1;
    old_hi = bus.hi_o; old_lo = bus.lo_o;
    bus.start_i = 1'b1; bus.op_i = op; bus.rs_i = rs; bus.rt_i = rt; bus.mf_req_i = 1'b0;
    c = 0; stall_cnt = 0; held = 1'b1; seen = 1'b0;
    while (!seen && c < 100) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (mf_at >= 0 && c >= mf_at) bus.mf_req_i = 1'b1;
      #1;
      if (bus.done_o) seen = 1'b1;
      else begin
        if (bus.stall_o) stall_cnt++;
        if (bus.hi_o !== old_hi || bus.lo_o !== old_lo) held = 1'b0;
        c++;
      end
    end
    chk({nm, " latency"}, 64'(c), 64'(lat));
    chk({nm, " stall cycles"}, 64'(stall_cnt), 64'(lat));
    chk({nm, " hi/lo held"}, 64'(held), 64'd1);
    chk({nm, " stall at done"}, 64'(bus.stall_o), 64'd0);
    chk({nm, " hi"}, 64'(bus.hi_o), 64'(eh));
    chk({nm, " lo"}, 64'(bus.lo_o), 64'(el));
`ifdef MULDIV_DIVZERO_EN
    chk({nm, " div_zero"}, 64'(bus.div_zero_o), 64'(edz));
`endif
    bus.start_i = 1'b0; bus.mf_req_i = 1'b0;
    @(posedge clk); #2;
    chk({nm, " done pulse"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    logic [31:0] eh, el, rs, rt;
    logic [1:0] op;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{OP_DIVU,  32'h00000055, 32'h00000000, 32'h00000055, 32'hFFFFFFFF};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.rs_i = '0; bus.rt_i = '0; bus.mf_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(bus.hi_o), 64'd0);
    chk("reset lo", 64'(bus.lo_o), 64'd0);
    chk("reset stall", 64'(bus.stall_o), 64'd0);
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset done", 64'(bus.done_o), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, -1);

    // Abort an operation in flight: HI/LO clear rather than complete.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = OP_MULTU; bus.rs_i = 32'h12345678; bus.rt_i = 32'h9;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-calc busy", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0; bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 64'(bus.busy_o), 64'd0);
    chk("abort stall", 64'(bus.stall_o), 64'd0);
    chk("abort hi", 64'(bus.hi_o), 64'd0);
    chk("abort lo", 64'(bus.lo_o), 64'd0);
    rst_n = 1'b1;
    run_op("after abort", OP_MULTU, 32'h12345678, 32'h9, 32'h0, 32'hA3D70A38, -1);

    // MFHI arriving mid-CALC keeps the stall and sees old HI until DONE.
    run_op("set hi", OP_DIVU, 32'h1234, 32'h10000, 32'h1234, 32'h0, -1);
    run_op("mf during calc", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (rt == 0) rt = 32'd1;
      model(op, rs, rt, eh, el);
      run_op($sformatf("rnd%0d op%0d", i, op), op, rs, rt, eh, el, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
